// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Fetch, data and shared-memory handshake bundle for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
  // Instruction-fetch requester
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  // Data-memory requester
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_done;
  // Shared memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_done, dm_rdata, dm_done, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_done, dm_rdata, dm_done, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between fetch and data requesters, with a
//            MAX_WAIT ack watchdog. Define ARB_ROUND_ROBIN_EN for alternating
//            grants under contention (default: data port has fixed priority).
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int MAX_WAIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus,
  output logic               busy,
  output logic               timeout_err
);

  localparam int                 c_CNT_W    = $clog2(MAX_WAIT) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BUSY_IF = 3'd1,
    S_BUSY_DM = 3'd2,
    S_DONE_IF = 3'd3,
    S_DONE_DM = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [31:0]        r_addr;
  logic               r_we;
  logic [31:0]        r_wdata;
  logic [31:0]        r_if_rdata;
  logic [31:0]        r_dm_rdata;
  logic [c_CNT_W-1:0] r_wait_cnt;
  logic               r_timeout_err;
  logic               w_grant_if;
  logic               w_grant_dm;
  logic               w_ack;
  logic               w_abort;
  logic               w_in_busy;

`ifdef ARB_ROUND_ROBIN_EN
  logic               r_last_dm;
`endif

  assign w_in_busy = (r_state == S_BUSY_IF) || (r_state == S_BUSY_DM);

  always_comb begin
    w_next_state = r_state;
    w_grant_if   = 1'b0;
    w_grant_dm   = 1'b0;
    w_ack        = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        // Under contention the port not granted last wins.
        w_grant_dm = bus.dm_req && (!bus.if_req || !r_last_dm);
`else
        w_grant_dm = bus.dm_req;
`endif
        w_grant_if = bus.if_req && !w_grant_dm;
        if (w_grant_dm) begin
          w_next_state = S_BUSY_DM;
        end else if (w_grant_if) begin
          w_next_state = S_BUSY_IF;
        end
      end
      S_BUSY_IF, S_BUSY_DM: begin
        if (bus.mem_ack) begin
          w_ack = 1'b1;
        end else if (r_wait_cnt == c_CNT_LAST) begin
          w_abort = 1'b1;
        end
        if (w_ack || w_abort) begin
          w_next_state = (r_state == S_BUSY_IF) ? S_DONE_IF : S_DONE_DM;
        end
      end
      S_DONE_IF, S_DONE_DM: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_addr        <= 32'h0;
      r_we          <= 1'b0;
      r_wdata       <= 32'h0;
      r_if_rdata    <= 32'h0;
      r_dm_rdata    <= 32'h0;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next_state;

      // Shared-port command is frozen at grant time for the whole access.
      if (w_grant_dm) begin
        r_addr  <= bus.dm_addr;
        r_we    <= bus.dm_we;
        r_wdata <= bus.dm_wdata;
      end else if (w_grant_if) begin
        r_addr  <= bus.if_addr;
        r_we    <= 1'b0;
        r_wdata <= 32'h0;
      end

      if (w_in_busy) begin
        if (w_ack || w_abort) begin
          r_wait_cnt <= '0;
        end else begin
          r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
        end
      end

      if (w_ack || w_abort) begin
        if (r_state == S_BUSY_IF) begin
          r_if_rdata <= w_ack ? bus.mem_rdata : 32'h0;
        end else begin
          r_dm_rdata <= w_ack ? bus.mem_rdata : 32'h0;
        end
      end

      if (w_abort) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_dm <= 1'b0;
    end else if (w_grant_dm || w_grant_if) begin
      r_last_dm <= w_grant_dm;
    end
  end
`endif

  assign bus.mem_req   = w_in_busy;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.if_done   = (r_state == S_DONE_IF);
  assign bus.dm_done   = (r_state == S_DONE_DM);
  assign busy          = (r_state != S_IDLE);
  assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire
